// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the instruction-memory boot loader.
//   state_e    - loader FSM states
//   HDR_BYTES  - bytes in the big-endian word-count header
//   WORD_BYTES - bytes per instruction word
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } state_e;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// byte_packer: collects four stream bytes into one 32-bit word, first byte in
// the most significant lane ({b0,b1,b2,b3}).
// Ports:
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   clear          - synchronous clear of the partial word (start of a frame)
//   in_byte        - byte to pack
//   in_take        - in_byte is consumed this cycle
//   word           - last completed word; holds its value between words
//   word_valid     - one-cycle pulse, the cycle after the 4th byte was taken
//   last_byte      - the next taken byte completes a word
module byte_packer
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  in_byte,
    input  logic        in_take,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        last_byte
);

    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] shift_next;
    logic [31:0] word_q, word_d;
    logic        word_valid_q, word_valid_d;

    // New byte enters lane 0, older bytes move one lane towards the MSB, so
    // after four bytes the first one sits in [31:24].
    assign shift_next[7:0] = in_byte;
    generate
        for (genvar gi = 1; gi < WORD_BYTES; gi++) begin : g_lane
            assign shift_next[gi*8 +: 8] = shift_q[(gi-1)*8 +: 8];
        end
    endgenerate

    assign last_byte = (byte_cnt_q == 2'(WORD_BYTES - 1));

    always_comb begin
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clear) begin
            byte_cnt_d = 2'd0;
            shift_d    = 32'd0;
        end else if (in_take) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = shift_next;
            if (last_byte) begin
                word_d       = shift_next;
                word_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_cnt_q   <= 2'd0;
            shift_q      <= 32'd0;
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
        end else begin
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word       = word_q;
    assign word_valid = word_valid_q;

endmodule

// File: rtl/instr_loader.sv
// instr_loader: boot-time loader in front of the CPU instruction memory.
// Receives a framed byte stream (4-byte big-endian word count N, N*4 payload
// bytes, 1 checksum byte = mod-256 sum of the payload), writes each packed
// word to memory and keeps the CPU in reset until a verified image is loaded.
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   start                 - begin a load (accepted in IDLE, DONE, ERROR)
//   in_data/in_valid/in_ready - byte stream handshake
//   mem_we/mem_addr/mem_wdata - one-cycle word write to instruction memory
//   cpu_reset             - high until a load completes successfully
//   done / error          - load result
module instr_loader
    import loader_pkg::*;
#(
    parameter int MEM_BYTES  = 1024,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    // Bound check against the word capacity so N*4 never has to be formed.
    localparam logic [31:0] MAX_WORDS = 32'(MEM_BYTES / WORD_BYTES);

    state_e                state_q, state_d;
    logic [1:0]            hdr_cnt_q, hdr_cnt_d;
    logic [31:0]           n_q, n_d;
    logic [31:0]           word_cnt_q, word_cnt_d;
    logic [7:0]            csum_q, csum_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

    logic        take;
    logic        enter_header;
    logic        hdr_last;
    logic [31:0] hdr_n;
    logic        payload_take;
    logic        last_byte;
    logic        word_valid;
    logic [31:0] packed_word;

    assign take         = in_valid && in_ready;
    assign enter_header = start && (state_q == ST_IDLE || state_q == ST_DONE
                                    || state_q == ST_ERROR);
    assign hdr_last     = (hdr_cnt_q == 2'(HDR_BYTES - 1));
    assign hdr_n        = {n_q[23:0], in_data};
    assign payload_take = take && (state_q == ST_PAYLOAD);

    byte_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (enter_header),
        .in_byte    (in_data),
        .in_take    (payload_take),
        .word       (packed_word),
        .word_valid (word_valid),
        .last_byte  (last_byte)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) state_d = ST_HEADER;
            end
            ST_HEADER: begin
                if (take && hdr_last) begin
                    if (hdr_n > MAX_WORDS)  state_d = ST_ERROR;
                    else if (hdr_n == 32'd0) state_d = ST_CHECK;
                    else                     state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (take && last_byte && (word_cnt_q + 32'd1 == n_q))
                    state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (take) state_d = (in_data == csum_q) ? ST_DONE : ST_ERROR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cpu_reset = 1'b1;
        case (state_q)
            ST_HEADER, ST_PAYLOAD, ST_CHECK: in_ready = 1'b1;
            ST_DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
            end
            ST_ERROR: error = 1'b1;
            default: ;
        endcase
    end

    // Datapath: header count, word counter, checksum, write address.
    always_comb begin
        hdr_cnt_d  = hdr_cnt_q;
        n_d        = n_q;
        word_cnt_d = word_cnt_q;
        csum_d     = csum_q;
        mem_addr_d = mem_addr_q;
        if (enter_header) begin
            hdr_cnt_d  = 2'd0;
            n_d        = 32'd0;
            word_cnt_d = 32'd0;
            csum_d     = 8'd0;
        end else if (take && state_q == ST_HEADER) begin
            hdr_cnt_d = hdr_cnt_q + 2'd1;
            n_d       = hdr_n;
        end else if (payload_take) begin
            csum_d = csum_q + in_data;
            if (last_byte) begin
                word_cnt_d = word_cnt_q + 32'd1;
                // Address is registered on the same edge the packer completes
                // the word, so it lines up with word_valid.
                mem_addr_d = ADDR_WIDTH'({word_cnt_q, 2'b00});
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hdr_cnt_q  <= 2'd0;
            n_q        <= 32'd0;
            word_cnt_q <= 32'd0;
            csum_q     <= 8'd0;
            mem_addr_q <= '0;
        end else begin
            hdr_cnt_q  <= hdr_cnt_d;
            n_q        <= n_d;
            word_cnt_q <= word_cnt_d;
            csum_q     <= csum_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign mem_we    = word_valid;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = packed_word;

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: scoreboard bench for instr_loader. Expected memory writes
// are queued as frames are driven and popped when mem_we is observed.
module tb_instr_loader;

    localparam int MEM_BYTES  = 1024;
    localparam int ADDR_WIDTH = 32;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  start;
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  cpu_reset;
    logic                  done;
    logic                  error;

    instr_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          writes_seen = 0;
    bit          gaps = 1'b0;
    logic [31:0] img [8];

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every observed write must match the oldest queued one.
    always @(negedge clock) begin
        if (mem_we === 1'b1) begin
            wr_t w;
            writes_seen++;
            if (exp_q.size() == 0) begin
                check_val("write_expected", 64'(exp_q.size()), 64'd1);
            end else begin
                w = exp_q.pop_front();
                check_val("mem_addr", 64'(mem_addr), 64'(w.addr));
                check_val("mem_wdata", 64'(mem_wdata), 64'(w.data));
                $display("write addr=%08h data=%08h", mem_addr, mem_wdata);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(negedge clock);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) check_val("in_ready_wait", 64'(in_ready), 64'd1);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
    endtask

    // Full frame of n words from img[]; checksum XOR-ed with csum_flip.
    task automatic send_frame(input int n, input logic [7:0] csum_flip);
        logic [7:0] sum;
        sum = 8'd0;
        pulse_start();
        send_word(32'(n));
        for (int i = 0; i < n; i++) begin
            sum = sum + img[i][31:24] + img[i][23:16] + img[i][15:8] + img[i][7:0];
            exp_q.push_back('{addr: 32'(i * 4), data: img[i]});
            send_word(img[i]);
        end
        send_byte(sum ^ csum_flip);
        $display("frame n=%0d csum=%02h done=%0b error=%0b", n, sum ^ csum_flip,
                 done, error);
    endtask

    task automatic check_reset_state(input string pfx);
        check_val({pfx, "_in_ready"}, 64'(in_ready), 64'd0);
        check_val({pfx, "_mem_we"}, 64'(mem_we), 64'd0);
        check_val({pfx, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check_val({pfx, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check_val({pfx, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
        check_val({pfx, "_done"}, 64'(done), 64'd0);
        check_val({pfx, "_error"}, 64'(error), 64'd0);
    endtask

    initial begin
        int w0;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_reset_state("rst");

        // Truncated payload: FF is taken as the 4th payload byte.
        pulse_start();
        send_word(32'd1);
        exp_q.push_back('{addr: 32'd0, data: 32'hC587B3FF});
        send_byte(8'hC5); send_byte(8'h87); send_byte(8'hB3); send_byte(8'hFF);
        check_val("trunc_done", 64'(done), 64'd0);
        check_val("trunc_in_check", 64'(in_ready), 64'd1);
        send_byte(8'h00);   // payload sum is FE, so this fails
        check_val("trunc_error", 64'(error), 64'd1);

        // Correct single-word frame.
        img[0] = 32'h00C587B3;
        send_frame(1, 8'h00);
        check_val("n1_done", 64'(done), 64'd1);
        check_val("n1_cpu_reset", 64'(cpu_reset), 64'd0);
        check_val("n1_in_ready", 64'(in_ready), 64'd0);

        // Two-word frame.
        img[0] = 32'h00000013; img[1] = 32'h00100093;
        send_frame(2, 8'h00);
        check_val("n2_done", 64'(done), 64'd1);

        // Bad checksum, then start clears error and reasserts cpu_reset.
        img[0] = 32'h00C587B3;
        send_frame(1, 8'hFF);
        check_val("bad_error", 64'(error), 64'd1);
        check_val("bad_cpu_reset", 64'(cpu_reset), 64'd1);
        check_val("bad_in_ready", 64'(in_ready), 64'd0);
        check_val("bad_done", 64'(done), 64'd0);
        pulse_start();
        check_val("restart_error", 64'(error), 64'd0);
        check_val("restart_in_ready", 64'(in_ready), 64'd1);

        // Already in HEADER: start ignored; N = 0x101 exceeds capacity.
        w0 = writes_seen;
        pulse_start();
        send_word(32'h00000101);
        check_val("len_error", 64'(error), 64'd1);
        check_val("len_in_ready", 64'(in_ready), 64'd0);
        repeat (3) @(negedge clock);
        check_val("len_no_write", 64'(writes_seen - w0), 64'd0);

        // N = 0: goes straight to CHECK, checksum 00.
        send_frame(0, 8'h00);
        check_val("n0_done", 64'(done), 64'd1);

        // N = 256: exactly at capacity, accepted.
        pulse_start();
        send_word(32'h00000100);
        check_val("cap_not_error", 64'(error), 64'd0);
        check_val("cap_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;

        // Reset after 6 payload bytes.
        pulse_start();
        send_word(32'd2);
        exp_q.push_back('{addr: 32'd0, data: 32'h11223344});
        send_word(32'h11223344);
        send_byte(8'h55); send_byte(8'h66);
        reset = 1'b1;
        @(negedge clock);
        check_reset_state("midrst");
        reset = 1'b0;
        img[0] = 32'hDEADBEEF; img[1] = 32'h01020304;
        send_frame(2, 8'h00);
        check_val("midrst_done", 64'(done), 64'd1);

        // Random in_valid gaps during the stream.
        gaps = 1'b1;
        img[0] = 32'hA5A5A5A5; img[1] = 32'h0F1E2D3C; img[2] = 32'hFFFFFFFF;
        img[3] = 32'h80000001;
        send_frame(4, 8'h00);
        gaps = 1'b0;
        check_val("gap_done", 64'(done), 64'd1);

        repeat (4) @(negedge clock);
        check_val("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
